// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared shift-operation types for the ALU blocks
package shifter_pkg;

    // Encoding is shared with other ALU blocks; do not reorder.
    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } shift_op_t;

    // Number of pipeline registers needed to cover 'layers' mux layers
    // when at most 'lps' layers sit between registers.
    function automatic int num_stages(input int layers, input int lps);
        return (layers + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/shift_layer.sv
// rtl/shift_layer.sv - one combinational mux2 layer of the barrel shifter
//
// Shifts or rotates data_i right/left by 2^K when en_i is set, otherwise
// passes it through unchanged.
//   data_i : operand entering this layer
//   op_i   : shift mode (SLL / SRL / SRA / ROR)
//   sign_i : sign of the original operand, used as SRA fill
//   en_i   : the shamt bit owned by this layer
//   data_o : layer result
module shift_layer
    import shifter_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 0
) (
    input  logic [N-1:0] data_i,
    input  shift_op_t    op_i,
    input  logic         sign_i,
    input  logic         en_i,
    output logic [N-1:0] data_o
);

    localparam int D = 1 << K;

    logic [N-1:0] shifted;

    always_comb begin
        shifted = data_i >> D;
        case (op_i)
            SLL:     shifted = data_i << D;
            SRL:     shifted = data_i >> D;
            // The original sign bit is used rather than data_i[N-1]; after
            // earlier layers the top bits are already sign copies anyway.
            SRA:     shifted = (data_i >> D) | ({N{sign_i}} << (N - D));
            ROR:     shifted = (data_i >> D) | (data_i << (N - D));
            default: shifted = data_i >> D;
        endcase
        data_o = en_i ? shifted : data_i;
    end

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - valid/ready pipelined barrel shifter
//
// Log-depth shifter: layer k moves the operand by 2^k when shamt[k] is set,
// LSB layer first. A register stage follows every LAYERS_PER_STAGE layers
// and the final layer, giving P stages of latency.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake
//   in_data             : operand (N bits)
//   in_shamt            : shift amount ($clog2(N) bits)
//   in_op               : shift_op_t mode
//   out_valid/out_ready : output handshake
//   out_data            : result, forced to zero while out_valid is low
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int N                = 32,
    parameter int LAYERS_PER_STAGE = 2,
    localparam int S               = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [S-1:0] in_shamt,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    localparam int LPS = LAYERS_PER_STAGE;
    localparam int P   = num_stages(S, LPS);

    // Stage registers
    logic [N-1:0] data_q  [P];
    logic [N-1:0] data_d  [P];
    logic [S-1:0] shamt_q [P];
    logic [S-1:0] shamt_d [P];
    shift_op_t    op_q    [P];
    shift_op_t    op_d    [P];
    logic [P-1:0] sign_q, sign_d;
    logic [P-1:0] valid_q, valid_d;

    // Values arriving at each stage register from its layers
    logic [N-1:0] stg_data  [P];
    logic [S-1:0] stg_shamt [P];
    shift_op_t    stg_op    [P];
    logic         stg_sign  [P];

    logic [P-1:0] src_valid;
    logic [P-1:0] load;

    // Layer chain. The first layer of each stage reads the previous stage
    // register (or the input port for layer 0); the others continue the
    // combinational chain from the layer below.
    for (genvar k = 0; k < S; k++) begin : g_layer
        localparam int ST = k / LPS;

        logic [N-1:0] d_in;
        logic [N-1:0] d_out;
        logic [S-1:0] sh;
        shift_op_t    op;
        logic         sign;

        if (k == 0) begin : g_from_input
            assign d_in = in_data;
            assign sh   = in_shamt;
            assign op   = shift_op_t'(in_op);
            assign sign = in_data[N-1];
        end else if (k % LPS == 0) begin : g_from_reg
            assign d_in = data_q[ST-1];
            assign sh   = shamt_q[ST-1];
            assign op   = op_q[ST-1];
            assign sign = sign_q[ST-1];
        end else begin : g_from_chain
            assign d_in = g_layer[k-1].d_out;
            assign sh   = g_layer[k-1].sh;
            assign op   = g_layer[k-1].op;
            assign sign = g_layer[k-1].sign;
        end

        shift_layer #(
            .N (N),
            .K (k)
        ) u_layer (
            .data_i (d_in),
            .op_i   (op),
            .sign_i (sign),
            .en_i   (sh[k]),
            .data_o (d_out)
        );
    end

    for (genvar j = 0; j < P; j++) begin : g_stage
        localparam int LAST = (((j + 1) * LPS < S) ? (j + 1) * LPS : S) - 1;

        assign stg_data[j]  = g_layer[LAST].d_out;
        assign stg_shamt[j] = g_layer[LAST].sh;
        assign stg_op[j]    = g_layer[LAST].op;
        assign stg_sign[j]  = g_layer[LAST].sign;
    end

    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid;
        for (int j = 1; j < P; j++) begin
            src_valid[j] = valid_q[j-1];
        end

        // A stage may load when any stage from itself to the output is
        // empty, or the output is being drained: either way everything
        // in front of it moves up by one, so bubbles collapse.
        load = '0;
        for (int j = 0; j < P; j++) begin
            load[j] = out_ready;
            for (int m = j; m < P; m++) begin
                if (!valid_q[m]) begin
                    load[j] = 1'b1;
                end
            end
        end

        sign_d  = sign_q;
        valid_d = valid_q;
        for (int j = 0; j < P; j++) begin
            data_d[j]  = data_q[j];
            shamt_d[j] = shamt_q[j];
            op_d[j]    = op_q[j];
            if (load[j]) begin
                valid_d[j] = src_valid[j];
                if (src_valid[j]) begin
                    data_d[j]  = stg_data[j];
                    shamt_d[j] = stg_shamt[j];
                    op_d[j]    = stg_op[j];
                    sign_d[j]  = stg_sign[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < P; j++) begin
                data_q[j]  <= '0;
                shamt_q[j] <= '0;
                op_q[j]    <= SLL;
            end
            sign_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int j = 0; j < P; j++) begin
                data_q[j]  <= data_d[j];
                shamt_q[j] <= shamt_d[j];
                op_q[j]    <= op_d[j];
            end
            sign_q  <= sign_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[P-1];
    assign out_data  = valid_q[P-1] ? data_q[P-1] : '0;

    // The last stage's control fields have no consumer downstream.
    logic unused_tail;
    assign unused_tail = ^{shamt_q[P-1], op_q[P-1], sign_q[P-1]};

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 SHALL have parameter N, default 32, meaning data width in bits (power of two, 8..64).
REQ-002 SHALL have parameter LAYERS_PER_STAGE, default 2, meaning mux2 layers between pipeline registers (1..$clog2(N)).
REQ-003 SHALL have derived localparam S = $clog2(N) (shift-amount width) and P = ceil(S / LAYERS_PER_STAGE) (register stages).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning the input operation is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the shifter accepts the input this cycle.
REQ-008 SHALL have port in_data, input, N, meaning the operand.
REQ-009 SHALL have port in_shamt, input, S, meaning the shift amount.
REQ-010 SHALL have port in_op, input, 2, meaning the shift_op_t mode.
REQ-011 SHALL have port out_valid, output, 1, meaning out_data holds a result.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-013 SHALL have port out_data, output, N, meaning the shifted result.

Function
REQ-014 SHALL treat an input transfer as in_valid && in_ready, and an output transfer as out_valid && out_ready.
REQ-015 SHALL implement modes SLL (zero fill), SRL (zero fill), SRA (sign fill from in_data[N-1]) and ROR (rotate right); shamt 0 SHALL return in_data unchanged in every mode.
REQ-016 SHALL realise the shift as S binary layers: layer k shifts or rotates by 2^k when shamt[k]=1, applied in LSB-first order.
REQ-017 SHALL place a pipeline register after every LAYERS_PER_STAGE layers and after the final layer; each register carries data, the remaining shamt bits, op, the sign bit and a valid bit.
REQ-018 SHALL have a latency of exactly P cycles from input transfer to out_valid when out_ready is held high (N=32, LPS=2 gives P=3).
REQ-019 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-020 SHALL let stage i load when it is empty or its contents advance this same cycle (bubble collapse); a stage holds its contents otherwise.
REQ-021 SHALL drive in_ready = stage-0 empty OR stage 0 advancing, combinationally and without depending on in_valid.
REQ-022 SHALL keep out_data stable while out_valid && !out_ready.
REQ-023 SHALL preserve order; no result SHALL be dropped or duplicated under any valid/ready pattern.
REQ-024 SHALL accept a new input on the same cycle the final stage is drained when all stages are full.
REQ-025 SHALL drive out_data all zeros whenever out_valid is 0.

Reset
REQ-026 SHALL, on rst_n low, immediately clear all stage valid bits and data registers to 0, so out_valid=0 and out_data=0.
REQ-027 SHALL assert in_ready in the first cycle after rst_n deasserts.
REQ-028 SHALL discard any in-flight operation when reset is asserted mid-operation; no result from it SHALL appear after reset.

Structure
REQ-029 SHALL take typedef shift_op_t {SLL=2'b00, SRL=2'b01, SRA=2'b10, ROR=2'b11} from shared package shifter_pkg, which other ALU blocks also import.
REQ-030 SHALL instantiate sub-module shift_layer (parameters N and K; purely combinational; one mux2 per bit selecting unshifted vs 2^K-shifted data with fill per op) once per layer via a generate loop.
REQ-031 SHALL contain sequential logic only in the pipeline registers and their valid bits.

Verification
REQ-032 Bench SHALL drive N=32, LPS=2: SRA 0x80000010 by 4 -> out_data 0xF8000001 exactly 3 cycles later.
REQ-033 Bench SHALL drive ROR 0x12345678 by 8 -> 0x78123456; SLL by 31 of 0x00000003 -> 0x80000000; SRL 0xFFFFFFFF by 0 -> 0xFFFFFFFF.
REQ-034 Bench SHALL drive 100 back-to-back random ops with out_ready=1 -> one result per cycle, matching the reference model in order.
REQ-035 Bench SHALL hold out_ready=0 for 6 cycles with continuous in_valid -> exactly P ops accepted, in_ready=0 thereafter, out_data stable, and none lost after release.
REQ-036 Bench SHALL assert rst_n low with 2 ops in flight -> out_valid=0 immediately and no stale result after release.
REQ-037 Bench SHALL run a sweep over N in {8, 64} and LPS in {1, S} with exhaustive shamt for all four ops -> results match the model and latency equals P.
